// File: rtl/apb_master_bridge.sv
// APB3 requester: turns a single-outstanding CPU request/ack port into APB SETUP/ACCESS
// cycles, returning read data and error status, and aborting transfers that never see PREADY.
module apb_master_bridge #(
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int unsigned TimerW = $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);
  localparam logic [TimerW-1:0] TimerMax  = '1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [TimerW-1:0]   timer_q, timer_d;

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;
    timer_d   = timer_q;

    case (state_q)
      StIdle: begin
        if (cpu_req) begin
          pwrite_d  = cpu_we;
          paddr_d   = cpu_addr;
          pwdata_d  = cpu_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        timer_d   = '0;
        state_d   = StAccess;
      end
      StAccess: begin
        // PREADY wins over the timeout when both land in the same cycle.
        if (PREADY) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          ack_d     = 1'b1;
          err_d     = PSLVERR;
          rdata_d   = (!pwrite_q && !PSLVERR) ? PRDATA : '0;
          state_d   = StIdle;
        end else if (timer_q == TimerLast) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          busy_d    = 1'b0;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
          state_d   = StIdle;
        end else if (timer_q != TimerMax) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      timer_q   <= timer_d;
    end
  end

  assign cpu_busy  = busy_q;
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule
